// File: rtl/add_result_fifo.sv
// add_result_fifo: first-word fall-through FIFO for 5-bit adder results,
//   with per-entry carry/zero flags, a saturating total of popped values
//   and a sticky drop flag.
// Latency: a push into an empty FIFO is visible on res_out/carry_out the
//   next cycle. Backpressure: in_ready drops when full (regardless of
//   out_ready); offers made while full are discarded and set drop_err.
//
// Ports:
//   clk, rst_n            rising-edge clock, async active-low reset
//   sum_in/in_valid/in_ready     producer side (sum_in[4] is the carry)
//   res_out/carry_out/zero_out/out_valid/out_ready   consumer side
//   clr                   synchronous flush of FIFO, total and drop flag
//   count                 occupied entries, 0..DEPTH
//   acc_total             saturating sum of popped 5-bit values
//   drop_err              sticky: a result was offered while full
module add_result_fifo #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2,
   parameter int ACC_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       sum_in,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             clr,
   output logic [3:0]       res_out,
   output logic             carry_out,
   output logic             zero_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PTR_W:0]   count,
   output logic [ACC_W-1:0] acc_total,
   output logic             drop_err
);

   localparam int CNT_W = PTR_W + 1;
   localparam int SUM_W = ACC_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [ACC_W-1:0] ACC_MAX  = {ACC_W{1'b1}};

   // Elaboration-time parameter sanity checks.
   if (PTR_W != $clog2(DEPTH)) begin : g_bad_ptr_w
      $error("add_result_fifo: PTR_W must equal log2(DEPTH)");
   end
   if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("add_result_fifo: DEPTH must be a power of two in 2..16");
   end
   if (ACC_W < 6) begin : g_bad_acc_w
      $error("add_result_fifo: ACC_W must be at least 6");
   end

   // Storage and state
   logic [4:0]       r_mem [DEPTH];
   logic [PTR_W-1:0] r_wp;
   logic [PTR_W-1:0] r_rp;
   logic [CNT_W-1:0] r_count;
   logic [ACC_W-1:0] r_acc;
   logic             r_drop;

   // Combinational status and handshake terms
   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic             w_drop;
   logic [4:0]       w_head;
   logic [SUM_W-1:0] w_acc_sum;
   logic [ACC_W-1:0] w_acc_next;

   assign w_full  = (r_count == FULL_CNT);
   assign w_empty = (r_count == '0);
   assign w_head  = r_mem[r_rp];

   // clr wins over everything that cycle, so it masks push, pop and drop.
   assign w_push = in_valid & ~w_full & ~clr;
   assign w_pop  = ~w_empty & out_ready & ~clr;
   // A pop in the same cycle does not open a slot for a full FIFO.
   assign w_drop = in_valid & w_full & ~clr;

   // One extra bit catches the overflow; clamp instead of wrapping.
   assign w_acc_sum  = {1'b0, r_acc} + SUM_W'(w_head);
   assign w_acc_next = w_acc_sum[ACC_W] ? ACC_MAX : w_acc_sum[ACC_W-1:0];

   // Memory is not reset: out_valid gates every use of its contents.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wp] <= sum_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
         r_acc   <= '0;
         r_drop  <= 1'b0;
      end else if (clr) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
         r_acc   <= '0;
         r_drop  <= 1'b0;
      end else begin
         // Power-of-two depth: natural pointer overflow is the modulo wrap.
         if (w_push) begin
            r_wp <= r_wp + PTR_W'(1);
         end
         if (w_pop) begin
            r_rp  <= r_rp + PTR_W'(1);
            r_acc <= w_acc_next;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
         if (w_drop) begin
            r_drop <= 1'b1;
         end
      end
   end

   // Outputs: head is forced to zero while empty so stale memory never leaks.
   assign in_ready  = ~w_full;
   assign out_valid = ~w_empty;
   assign res_out   = w_empty ? 4'h0 : w_head[3:0];
   assign carry_out = ~w_empty & w_head[4];
   assign zero_out  = ~w_empty & (w_head[3:0] == 4'h0);
   assign count     = r_count;
   assign acc_total = r_acc;
   assign drop_err  = r_drop;

endmodule

// File: tb/tb_add_result_fifo.sv
// tb_add_result_fifo: directed and randomized checks of add_result_fifo
//   against a queue-based reference model.
// Inputs change 1 time unit after each rising edge; outputs are sampled there.
module tb_add_result_fifo;

   localparam int DEPTH   = 4;
   localparam int PTR_W   = 2;
   localparam int ACC_W   = 8;
   localparam int ACC_MAX = (1 << ACC_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [4:0]       sum_in;
   logic             in_valid;
   logic             in_ready;
   logic             clr;
   logic [3:0]       res_out;
   logic             carry_out;
   logic             zero_out;
   logic             out_valid;
   logic             out_ready;
   logic [PTR_W:0]   count;
   logic [ACC_W-1:0] acc_total;
   logic             drop_err;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [4:0] m_q[$];
   int         m_acc;
   bit         m_drop;

   add_result_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W), .ACC_W(ACC_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sum_in    (sum_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .clr       (clr),
      .res_out   (res_out),
      .carry_out (carry_out),
      .zero_out  (zero_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .count     (count),
      .acc_total (acc_total),
      .drop_err  (drop_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare every output against what the model says it should be now.
   task automatic check_all(input string tag);
      logic [4:0] h;
      h = (m_q.size() != 0) ? m_q[0] : 5'h00;
      chk({tag, ".count"},     32'(count),     32'(m_q.size()));
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_q.size() != 0));
      chk({tag, ".in_ready"},  32'(in_ready),  32'(m_q.size() != DEPTH));
      chk({tag, ".res_out"},   32'(res_out),   32'(h[3:0]));
      chk({tag, ".carry_out"}, 32'(carry_out), 32'(h[4]));
      chk({tag, ".zero_out"},  32'(zero_out),  32'((m_q.size() != 0) && (h[3:0] == 4'h0)));
      chk({tag, ".acc_total"}, 32'(acc_total), 32'(m_acc));
      chk({tag, ".drop_err"},  32'(drop_err),  32'(m_drop));
   endtask

   task automatic drive(input bit iv, input logic [4:0] d, input bit ordy, input bit c);
      in_valid  = iv;
      sum_in    = d;
      out_ready = ordy;
      clr       = c;
   endtask

   // One clock: apply the FIFO rules to the pre-edge model state, then check.
   task automatic cyc(input string tag);
      bit full, empty;
      logic [4:0] h;
      full  = (m_q.size() == DEPTH);
      empty = (m_q.size() == 0);
      @(posedge clk);
      if (clr) begin
         m_q.delete();
         m_acc  = 0;
         m_drop = 1'b0;
      end else begin
         if (in_valid && full) m_drop = 1'b1;
         if (!empty && out_ready) begin
            h = m_q.pop_front();
            m_acc = (m_acc + int'(h) > ACC_MAX) ? ACC_MAX : m_acc + int'(h);
         end
         if (in_valid && !full) m_q.push_back(sum_in);
      end
      #1;
      check_all(tag);
   endtask

   initial begin
      logic [4:0] d;
      int         n;

      m_acc  = 0;
      m_drop = 1'b0;

      // Reset with a value already offered.
      rst_n = 1'b0;
      drive(1'b1, 5'h1F, 1'b0, 1'b0);
      #23;
      check_all("reset");
      rst_n = 1'b1;
      #1;
      check_all("released");
      cyc("first_push");
      chk("first_push.res_F", 32'(res_out), 32'hF);
      chk("first_push.carry", 32'(carry_out), 32'h1);

      // Flush, then fill with four values while the consumer stalls.
      drive(1'b0, 5'h00, 1'b0, 1'b1);
      cyc("clr0");
      drive(1'b1, 5'h03, 1'b0, 1'b0); cyc("fill0");
      drive(1'b1, 5'h10, 1'b0, 1'b0); cyc("fill1");
      drive(1'b1, 5'h0A, 1'b0, 1'b0); cyc("fill2");
      drive(1'b1, 5'h1F, 1'b0, 1'b0); cyc("fill3");
      chk("full.count", 32'(count), 32'd4);
      chk("full.in_ready", 32'(in_ready), 32'd0);
      chk("full.head", 32'(res_out), 32'h3);
      drive(1'b1, 5'h05, 1'b0, 1'b0); cyc("offer_full");
      chk("offer_full.drop_err", 32'(drop_err), 32'd1);
      chk("offer_full.count", 32'(count), 32'd4);

      // Drain in order; out_ready on an empty FIFO must be harmless.
      drive(1'b0, 5'h00, 1'b1, 1'b0); cyc("drain0");
      chk("drain0.head10_res", 32'(res_out), 32'h0);
      chk("drain0.head10_carry", 32'(carry_out), 32'h1);
      chk("drain0.head10_zero", 32'(zero_out), 32'h1);
      cyc("drain1");
      cyc("drain2");
      cyc("drain3");
      chk("drain.acc60", 32'(acc_total), 32'd60);
      chk("drain.out_valid", 32'(out_valid), 32'd0);
      cyc("empty_ready0");
      cyc("empty_ready1");
      chk("empty_ready.acc60", 32'(acc_total), 32'd60);

      // Steady state at count=2 with simultaneous push/pop across the wrap.
      drive(1'b0, 5'h00, 1'b0, 1'b1); cyc("clr1");
      drive(1'b1, 5'h01, 1'b0, 1'b0); cyc("pre0");
      drive(1'b1, 5'h02, 1'b0, 1'b0); cyc("pre1");
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 5'(3 + i), 1'b1, 1'b0);
         cyc("stream");
      end
      chk("stream.count2", 32'(count), 32'd2);
      chk("stream.acc", 32'(acc_total), 32'd21);

      // Saturation: keep pushing and popping 0x1F.
      drive(1'b0, 5'h00, 1'b0, 1'b1); cyc("clr2");
      drive(1'b1, 5'h1F, 1'b0, 1'b0); cyc("sat_prime");
      for (int i = 0; i < 11; i++) begin
         drive(1'b1, 5'h1F, 1'b1, 1'b0);
         cyc("sat");
      end
      chk("sat.hold255", 32'(acc_total), 32'd255);

      // clr with count=3, drop_err=1 and a push of 0x07 the same cycle.
      drive(1'b0, 5'h00, 1'b0, 1'b1); cyc("clr3");
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 5'(8 + i), 1'b0, 1'b0);
         cyc("refill");
      end
      drive(1'b1, 5'h0E, 1'b0, 1'b0); cyc("refill_drop");
      drive(1'b0, 5'h00, 1'b1, 1'b0); cyc("to_three");
      chk("pre_clr.count3", 32'(count), 32'd3);
      chk("pre_clr.drop", 32'(drop_err), 32'd1);
      drive(1'b1, 5'h07, 1'b0, 1'b1); cyc("clr_push");
      chk("clr_push.count", 32'(count), 32'd0);
      chk("clr_push.acc", 32'(acc_total), 32'd0);
      chk("clr_push.drop", 32'(drop_err), 32'd0);
      chk("clr_push.out_valid", 32'(out_valid), 32'd0);
      drive(1'b0, 5'h00, 1'b1, 1'b0);
      cyc("post_clr0");
      cyc("post_clr1");

      // Randomized traffic with occasional clr.
      for (int i = 0; i < 400; i++) begin
         d = 5'($urandom_range(0, 31));
         drive(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 2) != 0),
               1'($urandom_range(0, 39) == 0));
         cyc("rand");
      end

      // Asynchronous reset mid-operation loses all entries immediately.
      drive(1'b1, 5'h15, 1'b0, 1'b0);
      n = m_q.size();
      for (int i = n; i < 2; i++) cyc("pre_arst");
      #2;
      rst_n = 1'b0;
      m_q.delete();
      m_acc  = 0;
      m_drop = 1'b0;
      #1;
      check_all("arst");
      #10;
      rst_n = 1'b1;
      drive(1'b0, 5'h00, 1'b0, 1'b0);
      cyc("after_arst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
